// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locked arbiter sharing the UART TX path with paced writes
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_write,
    output logic [7:0]             uart_write_data,
    input  logic                   uart_tx_fifo_full,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_pulse,
    output logic [15:0]            frames_sent
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, SEND, SPACE} state_t;
    state_t state, state_n;
    logic [IW-1:0] g, rr_ptr, pick;
    logic [IW:0] idx;
    logic [CW-1:0] idle_cnt;
    logic [1:0] space_cnt;
    logic last_q, g_valid, xfer, tmo, done;
    assign busy = |grant;
    assign g_valid = req_valid[g];
    always_comb begin
        pick = rr_ptr;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
            if (req_valid[idx[IW-1:0]]) pick = idx[IW-1:0];
        end
    end
    always_comb begin
        state_n = state;
        req_ready = '0;
        xfer = 1'b0;
        tmo = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: state_n = |req_valid ? SEND : IDLE;
            SEND: begin
                req_ready = grant & req_valid & {NUM_REQ{~uart_tx_fifo_full}};
                xfer = g_valid & ~uart_tx_fifo_full;
                tmo = ~g_valid && idle_cnt == CW'(TIMEOUT_CYCLES - 1);
                state_n = xfer ? SPACE : tmo ? IDLE : SEND;
            end
            SPACE: begin
                done = space_cnt == 2'd1 && last_q;
                state_n = space_cnt != 2'd1 ? SPACE : last_q ? IDLE : SEND;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            g <= '0;
            rr_ptr <= '0;
            idle_cnt <= '0;
            space_cnt <= '0;
            last_q <= 1'b0;
            uart_write <= 1'b0;
            uart_write_data <= 8'h00;
            timeout_pulse <= 1'b0;
            frames_sent <= 16'h0000;
        end else begin
            state <= state_n;
            uart_write <= xfer;
            timeout_pulse <= tmo;
            // fifo-full stalls with valid high keep the idle counter cleared
            idle_cnt <= (state == SEND && !g_valid) ? idle_cnt + 1'b1 : '0;
            if (xfer) begin
                uart_write_data <= req_data[{g, 3'b000} +: 8];
                last_q <= req_last[g];
                space_cnt <= 2'd2;
            end else if (state == SPACE) begin
                space_cnt <= space_cnt - 1'b1;
            end
            if (state == IDLE && |req_valid) begin
                grant <= NUM_REQ'(1) << pick;
                g <= pick;
            end
            if (done || tmo) begin
                grant <= '0;
                rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            end
            if (done) frames_sent <= frames_sent + 16'd1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, cycle-exact checks of arbitration, pacing, back-pressure, timeout and reset
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0] req_last = '0;
    logic [3:0] req_ready;
    logic uart_write;
    logic [7:0] uart_write_data;
    logic uart_tx_fifo_full = 1'b0;
    logic [3:0] grant;
    logic busy;
    logic timeout_pulse;
    logic [15:0] frames_sent;
    int n_cmp = 0;
    int n_err = 0;
    int n_wr = 0;
    int exp_wr = 0;
    int exp_fs = 0;
    int bad;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_write(uart_write),
        .uart_write_data(uart_write_data), .uart_tx_fifo_full(uart_tx_fifo_full),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (uart_write) n_wr++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
        req_valid[r] = v;
        req_data[8*r +: 8] = d;
        req_last[r] = l;
    endtask

    task automatic reset_chk();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write", uart_write, 0);
        chk("rst_wdata", uart_write_data, 0);
        chk("rst_tpulse", timeout_pulse, 0);
        chk("rst_fsent", frames_sent, 0);
        chk("rst_ready", req_ready, 0);
    endtask

    // Requester r already owns the path in the current cycle; sends n bytes from b, last on the final one.
    task automatic frame(input int r, input logic [31:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            drive(r, 1'b1, b[8*k +: 8], k == n - 1);
            #1;
            chk("ready", req_ready, 1 << r);
            chk("grant", grant, 1 << r);
            cyc();
            exp_wr++;
            chk("wbyte", {uart_write, uart_write_data}, {1'b1, b[8*k +: 8]});
            if (k == n - 1) drive(r, 1'b0, 8'h00, 1'b0);
            cyc();
            chk("space", {req_ready, uart_write}, 0);
            cyc();
        end
        exp_fs++;
        chk("fsent", frames_sent, exp_fs);
        chk("gdone", grant, 0);
    endtask

    initial begin
        cyc();
        cyc();
        reset_chk();
        reset = 1'b0;
        // single requester, 3-byte frame
        drive(0, 1'b1, 8'h41, 1'b0);
        #1 chk("idle_ready", req_ready, 0);
        cyc();
        frame(0, 32'h00434241, 3);
        chk("busy_end", busy, 0);
        // rr_ptr is now 1: req1 wins over req0, and its frame is not interleaved
        drive(0, 1'b1, 8'h55, 1'b1);
        drive(1, 1'b1, 8'h10, 1'b0);
        cyc();
        chk("rr_after_req0", grant, 4'b0010);
        frame(1, 32'h13121110, 4);
        cyc();
        chk("req0_next", grant, 4'b0001);
        frame(0, 32'h00000055, 1);
        // back-pressure for 500 cycles, far beyond the 16-cycle timeout
        drive(2, 1'b1, 8'h61, 1'b0);
        cyc();
        chk("bp_grant", grant, 4'b0100);
        uart_tx_fifo_full = 1'b1;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            #1;
            if (req_ready != 0 || uart_write || timeout_pulse || grant != 4'b0100) bad++;
            cyc();
        end
        chk("bp_stall", bad, 0);
        uart_tx_fifo_full = 1'b0;
        frame(2, 32'h00006261, 2);
        // timeout: req2 sends one byte, drops valid; req3 waits
        drive(2, 1'b1, 8'h71, 1'b0);
        cyc();
        chk("to_grant", grant, 4'b0100);
        drive(3, 1'b1, 8'h81, 1'b1);
        #1 chk("to_ready", req_ready, 4'b0100);
        cyc();
        exp_wr++;
        chk("to_wbyte", {uart_write, uart_write_data}, {1'b1, 8'h71});
        drive(2, 1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (timeout_pulse || grant != 4'b0100) bad++;
            cyc();
        end
        chk("to_early", bad, 0);
        chk("to_pulse", timeout_pulse, 1);
        chk("to_gclear", grant, 0);
        chk("to_fsent", frames_sent, exp_fs);
        cyc();
        chk("to_pulse_end", timeout_pulse, 0);
        chk("to_next", grant, 4'b1000);
        // reset during SPACE of req3's frame; rr_ptr must return to 0
        #1 chk("r3_ready", req_ready, 4'b1000);
        cyc();
        exp_wr++;
        chk("r3_wbyte", {uart_write, uart_write_data}, {1'b1, 8'h81});
        drive(0, 1'b1, 8'hB0, 1'b1);
        reset = 1'b1;
        cyc();
        reset_chk();
        reset = 1'b0;
        exp_fs = 0;
        cyc();
        chk("post_rst_grant", grant, 4'b0001);
        frame(0, 32'h000000B0, 1);
        cyc();
        chk("post_rst_r3", grant, 4'b1000);
        frame(3, 32'h00000081, 1);
        // round-robin from a fresh reset, all four pending
        reset = 1'b1;
        cyc();
        cyc();
        reset_chk();
        reset = 1'b0;
        exp_fs = 0;
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr_order", grant, 1 << i);
            frame(i, 32'hA0 + i, 1);
        end
        chk("rr_fsent", frames_sent, 4);
        cyc();
        chk("write_count", n_wr, exp_wr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
